// File: rtl/password_pkg.sv
// Shared types and helpers for the password checker.
// Optional attempt-limit support is enabled with PASSWORD_CHECKER_LIMIT_EN.
package password_pkg;

  localparam int unsigned CHAR_W  = 8;
  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned PW_W    = CHAR_W * MAX_LEN;
  localparam int unsigned LANE_W  = 3;
  localparam int unsigned LEN_W   = 8;
  localparam int unsigned IDX_W   = $clog2(MAX_LEN + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_READY = 3'd2,
    ST_CHECK = 3'd3,
    ST_FOUND = 3'd4
`ifdef PASSWORD_CHECKER_LIMIT_EN
    ,
    ST_DONE  = 3'd5
`endif
  } checker_state_t;

  // Byte-enable for the first len characters; zero for an out-of-range length.
  function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] len);
    logic [MAX_LEN-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      m[i] = (LEN_W'(i) < len) && (len <= LEN_W'(MAX_LEN));
    end
    return m;
  endfunction

endpackage

// File: rtl/password_match_stage.sv
// Two-stage registered candidate/target compare.
// Stage 1 captures the candidate with a per-byte equality mask and a length
// flag; stage 2 reduces them to a single match bit alongside the candidate.
module password_match_stage
  import password_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [PW_W-1:0]   in_password,
  input  logic [LEN_W-1:0]  in_length,
  input  logic [LANE_W-1:0] in_lane,
  input  logic [PW_W-1:0]   target,
  input  logic [LEN_W-1:0]  target_length,
  output logic              out_valid,
  output logic              out_match,
  output logic [PW_W-1:0]   out_password,
  output logic [LEN_W-1:0]  out_length,
  output logic [LANE_W-1:0] out_lane
);

  logic [MAX_LEN-1:0] eq_c;
  logic               len_ok_c;

  logic               s1_valid;
  logic [PW_W-1:0]    s1_password;
  logic [LEN_W-1:0]   s1_length;
  logic [LANE_W-1:0]  s1_lane;
  logic [MAX_LEN-1:0] s1_mask;
  logic               s1_len_eq;

  // Per-byte equality of the incoming candidate against the target.
  always_comb begin
    eq_c = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      eq_c[i] = (in_password[i*CHAR_W +: CHAR_W] == target[i*CHAR_W +: CHAR_W]);
    end
  end

  assign len_ok_c = (in_length != '0) && (in_length <= LEN_W'(MAX_LEN));

  // Stage 1: register candidate, byte mask and length-equal flag.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1_valid    <= 1'b0;
      s1_password <= '0;
      s1_length   <= '0;
      s1_lane     <= '0;
      s1_mask     <= '0;
      s1_len_eq   <= 1'b0;
    end else begin
      s1_valid <= in_valid && !flush;
      if (in_valid) begin
        s1_password <= in_password;
        s1_length   <= in_length;
        s1_lane     <= in_lane;
        s1_mask     <= eq_c;
        s1_len_eq   <= len_ok_c && (in_length == target_length);
      end
    end
  end

  // Stage 2: bytes beyond the length are forced equal before the AND-reduce.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_valid    <= 1'b0;
      out_match    <= 1'b0;
      out_password <= '0;
      out_length   <= '0;
      out_lane     <= '0;
    end else begin
      out_valid <= s1_valid && !flush;
      if (s1_valid) begin
        out_match    <= s1_len_eq && (&(s1_mask | ~len_mask(s1_length)));
        out_password <= s1_password;
        out_length   <= s1_length;
        out_lane     <= s1_lane;
      end
    end
  end

endmodule

// File: rtl/password_checker.sv
// Password checker: byte-serial target load, pipelined candidate compare,
// match latch and generator stop. Define PASSWORD_CHECKER_LIMIT_EN to add
// the attempt limit (exhausted output, DONE state).
module password_checker
  import password_pkg::*;
#(
  parameter int unsigned      CNT_W        = 32,
  parameter logic [CNT_W-1:0] MAX_ATTEMPTS = {CNT_W{1'b1}}
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load_valid,
  input  logic [CHAR_W-1:0] load_char,
  input  logic              load_last,
  input  logic              start,
  input  logic              clear,
  input  logic              cand_valid,
  output logic              cand_ready,
  input  logic [PW_W-1:0]   cand_password,
  input  logic [LEN_W-1:0]  cand_length,
  input  logic [LANE_W-1:0] cand_lane,
  output logic              found,
  output logic [PW_W-1:0]   found_password,
  output logic [LEN_W-1:0]  found_length,
  output logic [LANE_W-1:0] found_lane,
  output logic [CNT_W-1:0]  attempts,
  output logic              stop,
  output logic              busy,
  output logic              load_error,
  output logic              exhausted
);

  checker_state_t    state;
  logic [PW_W-1:0]   target;
  logic [LEN_W-1:0]  target_length;
  logic [IDX_W-1:0]  idx;

  logic              s2_valid;
  logic              s2_match;
  logic [PW_W-1:0]   s2_password;
  logic [LEN_W-1:0]  s2_length;
  logic [LANE_W-1:0] s2_lane;

  logic              accept_c;
  logic              flush_c;
  logic              limit_hit_c;
  logic [CNT_W-1:0]  attempts_inc_c;

  assign accept_c       = cand_valid && cand_ready;
  assign attempts_inc_c = (attempts == {CNT_W{1'b1}}) ? attempts : attempts + CNT_W'(1);

`ifdef PASSWORD_CHECKER_LIMIT_EN
  assign limit_hit_c = s2_valid && !s2_match && (attempts_inc_c == MAX_ATTEMPTS);
`else
  logic unused_limit;
  assign limit_hit_c  = 1'b0;
  assign exhausted    = 1'b0;
  assign unused_limit = ^MAX_ATTEMPTS;
`endif

  // Empty the pipe whenever the search ends or is abandoned this cycle.
  assign flush_c = (state != ST_CHECK) || clear || (s2_valid && (s2_match || limit_hit_c));

  password_match_stage u_match (
    .clock         (clock),
    .reset_n       (reset_n),
    .flush         (flush_c),
    .in_valid      (accept_c),
    .in_password   (cand_password),
    .in_length     (cand_length),
    .in_lane       (cand_lane),
    .target        (target),
    .target_length (target_length),
    .out_valid     (s2_valid),
    .out_match     (s2_match),
    .out_password  (s2_password),
    .out_length    (s2_length),
    .out_lane      (s2_lane)
  );

  // Checker FSM with target storage, attempt counter and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      target         <= '0;
      target_length  <= '0;
      idx            <= '0;
      load_error     <= 1'b0;
      cand_ready     <= 1'b0;
      busy           <= 1'b0;
      found          <= 1'b0;
      found_password <= '0;
      found_length   <= '0;
      found_lane     <= '0;
      attempts       <= '0;
      stop           <= 1'b0;
`ifdef PASSWORD_CHECKER_LIMIT_EN
      exhausted      <= 1'b0;
`endif
    end else if (clear && (state != ST_IDLE) && (state != ST_LOAD)) begin
      // Clear beats a same-cycle match; the target itself is kept.
      found          <= 1'b0;
      found_password <= '0;
      found_length   <= '0;
      found_lane     <= '0;
      attempts       <= '0;
      stop           <= 1'b0;
      cand_ready     <= 1'b0;
      busy           <= 1'b0;
`ifdef PASSWORD_CHECKER_LIMIT_EN
      exhausted      <= 1'b0;
`endif
      state          <= (target_length != '0) ? ST_READY : ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE, ST_READY: begin
          if (load_valid) begin
            target[CHAR_W-1:0] <= load_char;
            idx                <= IDX_W'(1);
            load_error         <= 1'b0;
            if (load_last) begin
              target_length <= LEN_W'(1);
              state         <= ST_READY;
            end else begin
              target_length <= '0;
              state         <= ST_LOAD;
            end
          end else if (start && (state == ST_READY)) begin
            state      <= ST_CHECK;
            cand_ready <= 1'b1;
            busy       <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (load_valid) begin
            if (idx == IDX_W'(MAX_LEN)) begin
              load_error    <= 1'b1;
              target_length <= '0;
              state         <= ST_IDLE;
            end else begin
              target[32'(idx) * CHAR_W +: CHAR_W] <= load_char;
              idx <= idx + IDX_W'(1);
              if (load_last) begin
                target_length <= LEN_W'(idx) + LEN_W'(1);
                state         <= ST_READY;
              end
            end
          end
        end
        ST_CHECK: begin
          if (s2_valid) begin
            attempts <= attempts_inc_c;
            if (s2_match) begin
              found          <= 1'b1;
              found_password <= s2_password;
              found_length   <= s2_length;
              found_lane     <= s2_lane;
              stop           <= 1'b1;
              cand_ready     <= 1'b0;
              busy           <= 1'b0;
              state          <= ST_FOUND;
            end
`ifdef PASSWORD_CHECKER_LIMIT_EN
            else if (limit_hit_c) begin
              exhausted  <= 1'b1;
              stop       <= 1'b1;
              cand_ready <= 1'b0;
              busy       <= 1'b0;
              state      <= ST_DONE;
            end
`endif
          end
        end
        default: begin
          // FOUND / DONE: hold everything until clear or reset.
        end
      endcase
    end
  end

endmodule

// File: doc/password_checker.md
Name: password_checker

Overview:
Receiving end of the brute-force generator lanes. It holds a target password that is loaded byte-serially. Candidate passwords (128-bit, 16 ASCII chars, char 0 in bits [7:0]) arrive from the generators over a valid/ready handshake and are compared through a 2-stage pipeline. On a match it latches the password, its length and the originating lane, and asserts stop so the generators' enable can be dropped.

Parameters:
MAX_LEN, 16, maximum password length in characters (PW_W = 8*MAX_LEN).
CNT_W, 32, width of the attempts counter.
MAX_ATTEMPTS, 2**32-1, attempt limit; used only with PASSWORD_CHECKER_LIMIT_EN.

Ports:
clock  in  1  single clock; all state updates on the rising edge.
reset_n  in  1  synchronous, active-low reset.
load_valid  in  1  one target character is present this cycle.
load_char  in  8  target character; the first byte is char 0.
load_last  in  1  marks the final target character.
start  in  1  pulse; begin accepting candidates.
clear  in  1  pulse; abandon or finish the search.
cand_valid  in  1  candidate present.
cand_ready  out  1  checker accepts a candidate this cycle.
cand_password  in  128  candidate characters.
cand_length  in  8  candidate length in characters.
cand_lane  in  3  generator lane id (that lane's startingPosition).
found  out  1  match latched.
found_password  out  128  matching candidate.
found_length  out  8  matching length.
found_lane  out  3  lane that produced the match.
attempts  out  CNT_W  candidates evaluated.
stop  out  1  generators must halt.
busy  out  1  state is CHECK.
load_error  out  1  target exceeded MAX_LEN.
exhausted  out  1  attempt limit reached (tied 0 without the macro).

Behaviour:
- Reset (reset_n=0 at an edge, including mid-search): state IDLE. All outputs are 0. Target length is 0. Pipeline valids are cleared.
- States: IDLE, LOAD, READY, CHECK, FOUND (plus DONE with the macro).
- IDLE/READY:
  - A load_valid cycle writes char 0, sets idx=1 and clears load_error.
  - If load_last is also set, go to READY with target length 1; otherwise go to LOAD.
  - In READY, load_valid restarts the load from char 0.
- LOAD:
  - Each load_valid cycle writes char idx and increments idx.
  - load_last records target length = idx+1 and moves to READY.
  - A byte written at idx = MAX_LEN sets load_error (sticky), sets target length to 0 and returns to IDLE.
- start in READY moves to CHECK. start in any other state is ignored.
- CHECK:
  - cand_ready=1; a transfer occurs when cand_valid && cand_ready.
  - Stage 1 registers the candidate and computes a 16-bit per-byte equality mask and a length-equal flag.
  - Stage 2 produces the match: length equal, AND all bytes 0..len-1 equal. Bytes at or beyond the length are ignored.
  - cand_length of 0 or greater than MAX_LEN never matches.
  - Each candidate reaching stage 2 increments attempts, saturating at all-ones.
  - Latency: a candidate accepted at cycle N asserts found/stop at cycle N+2.
- On a match:
  - found_* are latched; found=1, stop=1; next state FOUND.
  - cand_ready is 0 from the cycle found rises.
  - A candidate in stage 1 at that moment is discarded and not counted.
- FOUND: outputs are held stable and candidates are refused.
- clear (any state except IDLE/LOAD):
  - Zeroes found, stop, exhausted, attempts and the pipeline.
  - Goes to READY if target length > 0, else IDLE. The target is retained.
- Clear and match in the same cycle: clear wins and found stays 0.

Optional Feature:
PASSWORD_CHECKER_LIMIT_EN:
- When defined: if attempts reaches MAX_ATTEMPTS with no match in that cycle, exhausted=1, stop=1, state DONE. DONE behaves like FOUND without found, and is left only via clear or reset. A match in the same cycle takes priority over exhaustion.
- When undefined: no limit logic, exhausted is tied 0, and attempts saturates silently.

Decomposition:
- Package password_pkg:
  - CHAR_W=8, MAX_LEN, PW_W, LANE_W=3.
  - checker_state_t enum.
  - Helper function for the length mask (len -> 16-bit byte-enable).
- Sub-module password_match_stage: the registered 2-stage byte compare (mask, length check, valid pipe). The FSM, target storage and counters stay in the top level.

Test Plan:
- Load "abc" (0x61,0x62,0x63 with load_last on the third byte), start, then send candidates "abb", "abd", "abc" on lane 5, back-to-back → found at cycle of "abc" accept + 2; found_password[23:0]=0x636261, found_length=3, found_lane=5, attempts=3, stop=1.
- Same target; candidate "abc" with cand_length=4 and byte 3 = 0x00 → no match. "abcx" with length 3 → matches (upper bytes ignored).
- Load 17 bytes without load_last → load_error=1, state IDLE. A following start is ignored and busy stays 0.
- Match with a second candidate already in stage 1 → attempts counts only the matching candidate's sequence; the second candidate is dropped; cand_ready=0 in FOUND.
- Assert clear in the same cycle as a match → found=0, attempts=0, state READY. Then start and replay the matching candidate → found=1.
- With PASSWORD_CHECKER_LIMIT_EN and MAX_ATTEMPTS=4: send 4 non-matching candidates → exhausted=1 and stop=1 two cycles after the 4th is accepted. Assert reset_n=0 mid-search → all outputs 0 next edge.
